// File: rtl/ones_pattern_gen_if.sv
// Shared widths and the request/result bundle for ones_pattern_gen, including
// the controller probe signals brought out for observation.
package q_8_34a_pkg;
  parameter int data_size = 8;
  parameter int r2_size   = 4;
endpackage

interface ones_pattern_gen_if;
  import q_8_34a_pkg::*;

  logic                 start;
  logic [r2_size-1:0]   cnt_in;
  logic [data_size-1:0] data_out;
  logic                 rdy;
  logic                 ovf;
  logic                 load_regs;
  logic                 shift;
  logic                 decr_r2;
  logic                 zero;

  modport master (
    output start, cnt_in,
    input  data_out, rdy, ovf, load_regs, shift, decr_r2, zero
  );

  modport slave (
    input  start, cnt_in,
    output data_out, rdy, ovf, load_regs, shift, decr_r2, zero
  );
endinterface

// File: rtl/ones_pattern_gen.sv
// Count-to-pattern converter: emits a word with cnt_in ones, one bit per cycle.
// Build option ONES_PATTERN_MSB_FILL_EN fills from the MSB instead of the LSB.
//
// state  | meaning
// S_idle | rdy high, data_out/ovf hold, waiting for start
// S_1    | shifting in a one per cycle until R2 reaches zero
module ones_pattern_gen
  import q_8_34a_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  ones_pattern_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    S_idle = 2'd0,
    S_1    = 2'd1
  } state_t;

  localparam logic [r2_size-1:0] MAX_CNT = r2_size'(data_size);

  if (data_size >= (1 << r2_size)) begin : g_width_chk
    $error("r2_size too narrow to hold data_size");
  end

  state_t               state_q, state_d;
  logic [data_size-1:0] r1_q, r1_d;
  logic [r2_size-1:0]   r2_q, r2_d;
  logic                 ovf_q, ovf_d;
  logic                 rdy_q, rdy_d;
  logic                 load_regs, shift, decr_r2, zero, over;

  always_comb begin
    state_d   = state_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    ovf_d     = ovf_q;
    zero      = (r2_q == '0);
    over      = (bus.cnt_in > MAX_CNT);
    load_regs = (state_q == S_idle) && bus.start;
    shift     = (state_q == S_1) && !zero;
    decr_r2   = shift;

    case (state_q)
      S_idle: begin
        if (bus.start) begin
          r1_d    = '0;
          r2_d    = over ? MAX_CNT : bus.cnt_in;
          ovf_d   = over;
          state_d = S_1;
        end
      end
      S_1: begin
        if (zero) begin
          state_d = S_idle;
        end else begin
`ifdef ONES_PATTERN_MSB_FILL_EN
          r1_d = {1'b1, r1_q[data_size-1:1]};
`else
          r1_d = {r1_q[data_size-2:0], 1'b1};
`endif
          r2_d = r2_q - 1'b1;
        end
      end
      default: state_d = S_idle;
    endcase

    // rdy is registered from the next state so it tracks S_idle exactly
    rdy_d = (state_d == S_idle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_idle;
      r1_q    <= '0;
      r2_q    <= '0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      ovf_q   <= ovf_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.data_out  = r1_q;
  assign bus.rdy       = rdy_q;
  assign bus.ovf       = ovf_q;
  assign bus.load_regs = load_regs;
  assign bus.shift     = shift;
  assign bus.decr_r2   = decr_r2;
  assign bus.zero      = zero;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Scoreboard bench for ones_pattern_gen: directed launches push expectations,
// a monitor pops and checks them on every rdy rise.
module tb_ones_pattern_gen;
  import q_8_34a_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ones_pattern_gen_if bus();

  ones_pattern_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] pat;
    logic       ovf;
    int         lat;
    int         ones;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  logic mon_prev = 1'b1;
  int   mon_low = 0;
  logic [7:0] last_pat = 8'h00;

  function automatic logic [7:0] fill(input logic [7:0] lsb_pat);
    logic [7:0] r;
`ifdef ONES_PATTERN_MSB_FILL_EN
    for (int i = 0; i < 8; i++) r[i] = lsb_pat[7-i];
`else
    r = lsb_pat;
`endif
    return r;
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: counts rdy-low cycles and checks the result on each rdy rise
  initial begin
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (!bus.rdy) begin
        mon_low++;
      end else if (!mon_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("data_out", int'(bus.data_out), int'(mon_e.pat));
          check("ovf", int'(bus.ovf), int'(mon_e.ovf));
          check("rdy_low_cycles", mon_low, mon_e.lat);
          check("countones", $countones(bus.data_out), mon_e.ones);
        end
        mon_low = 0;
      end
      mon_prev = bus.rdy;
    end
  end

  task automatic launch(input logic [3:0] cnt, input logic [7:0] pat_lsb,
                        input logic ovf, input int lat, input int ones,
                        input bit keep_start);
    exp_t e;
    logic ready = 1'b0;
    for (int i = 0; i < 200 && !ready; i++) begin
      @(negedge clk);
      ready = bus.rdy;
    end
    if (!ready) check("rdy_timeout", 0, 1);
    bus.cnt_in = cnt;
    bus.start  = 1'b1;
    e.pat  = fill(pat_lsb);
    e.ovf  = ovf;
    e.lat  = lat;
    e.ones = ones;
    exp_q.push_back(e);
    last_pat = e.pat;
    @(posedge clk);
    #1;
    if (!keep_start) bus.start = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.cnt_in = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_rdy", int'(bus.rdy), 1);
    check("reset_data_out", int'(bus.data_out), 0);
    check("reset_ovf", int'(bus.ovf), 0);
    check("reset_zero", int'(bus.zero), 1);
    mon_en = 1'b1;

    launch(4'd3,  8'h07, 1'b0, 4, 3, 1'b0);
    launch(4'd0,  8'h00, 1'b0, 1, 0, 1'b0);
    launch(4'd8,  8'hFF, 1'b0, 9, 8, 1'b0);
    launch(4'd12, 8'hFF, 1'b1, 9, 8, 1'b0);

    // Reset during the third S_1 cycle aborts the run with nothing retained
    launch(4'd5,  8'h00, 1'b0, 3, 0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    launch(4'd2,  8'h03, 1'b0, 3, 2, 1'b0);

    // cnt_in changes while shifting must not alter the result
    launch(4'd2,  8'h03, 1'b0, 3, 2, 1'b0);
    @(negedge clk);
    bus.cnt_in = 4'd7;

    // start held high: relaunch on every single-cycle rdy window
    launch(4'd0, 8'h00, 1'b0, 1, 0, 1'b1);
    launch(4'd1, 8'h01, 1'b0, 2, 1, 1'b1);
    launch(4'd2, 8'h03, 1'b0, 3, 2, 1'b1);
    launch(4'd3, 8'h07, 1'b0, 4, 3, 1'b1);
    launch(4'd4, 8'h0F, 1'b0, 5, 4, 1'b1);
    launch(4'd5, 8'h1F, 1'b0, 6, 5, 1'b1);
    launch(4'd6, 8'h3F, 1'b0, 7, 6, 1'b1);
    launch(4'd7, 8'h7F, 1'b0, 8, 7, 1'b1);
    launch(4'd8, 8'hFF, 1'b0, 9, 8, 1'b0);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    check("hold_data_out", int'(bus.data_out), int'(last_pat));
    check("hold_rdy", int'(bus.rdy), 1);
    check("hold_ovf", int'(bus.ovf), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
